// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the Wishbone memory arbiter
package wb_arb_pkg;

  // Widest bus the captured request record can carry; narrower buses zero-extend into it.
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  // Master identifiers, also used as the round-robin history value.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Request fields frozen at grant time and replayed to the slave.
  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // One-hot grant vector for a given owner.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// rtl/wb_mem_arbiter_if.sv - Wishbone classic bus bundle with master/slave views
interface wb_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [SEL_WIDTH-1:0]  sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_w;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  ack;

  // Side that starts cycles.
  modport master (
    output cyc, stb, we, sel, addr, data_w,
    input  data_r, ack
  );

  // Side that answers cycles.
  modport slave (
    input  cyc, stb, we, sel, addr, data_w,
    output data_r, ack
  );

endinterface

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - two-way round-robin select between pending requests
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the master that did not go last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == M1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master round-robin Wishbone arbiter with abort and timeout
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = WB_ADDR_W,
  parameter int                    DATA_WIDTH     = WB_DATA_W,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic             clk_core,
  input  logic             rst_core,
  wb_mem_arbiter_if.slave  m0,
  wb_mem_arbiter_if.slave  m1,
  wb_mem_arbiter_if.master s,
  output logic [1:0]       grant_o,
  output logic             timeout_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // A zero timeout disables the watchdog; keep at least one counter bit so the logic stays legal.
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int              CNT_W    = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_cyc_q, s_cyc_d;
  logic             timeout_q, timeout_d;
  logic             load_req;
  wb_req_t          req_q;
  wb_req_t          in_req;

  logic [1:0]            req;
  logic [1:0]            pick_gnt;
  logic                  busy;
  logic                  owner_cyc;
  logic                  ack_hit;
  logic                  abort_hit;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] resp_data;

  assign req = {m1.cyc & m1.stb, m0.cyc & m0.stb};

  wb_rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  // Completion events are prioritised ack > abort > timeout so a real answer is never discarded.
  assign busy      = (state_q == BUSY);
  assign owner_cyc = (owner_q == M1) ? m1.cyc : m0.cyc;
  assign ack_hit   = busy & s.ack;
  assign abort_hit = busy & ~ack_hit & ~owner_cyc;
  assign tmo_hit   = TMO_EN & busy & ~ack_hit & ~abort_hit & (cnt_q == TMO_LAST);

  // Fields of whichever master the picker selects, frozen into req_q on grant.
  always_comb begin
    in_req = '0;
    if (pick_gnt[1]) begin
      in_req.we   = m1.we;
      in_req.sel  = WB_SEL_W'(m1.sel);
      in_req.addr = WB_ADDR_W'(m1.addr);
      in_req.data = WB_DATA_W'(m1.data_w);
    end else begin
      in_req.we   = m0.we;
      in_req.sel  = WB_SEL_W'(m0.sel);
      in_req.addr = WB_ADDR_W'(m0.addr);
      in_req.data = WB_DATA_W'(m0.data_w);
    end
  end

  // Arbiter state, ownership history, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q   <= IDLE;
      owner_q   <= M0;
      last_q    <= M1;
      cnt_q     <= '0;
      s_cyc_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_cyc_q   <= s_cyc_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: grant from IDLE, then leave BUSY on ack, abort or watchdog expiry.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_cyc_d   = s_cyc_q;
    timeout_d = timeout_q;
    load_req  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|pick_gnt) begin
          state_d  = BUSY;
          owner_d  = pick_gnt[1];
          load_req = 1'b1;
          s_cyc_d  = 1'b1;
        end
      end
      BUSY: begin
        if (ack_hit) begin
          state_d = IDLE;
          s_cyc_d = 1'b0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (abort_hit) begin
          state_d = IDLE;
          s_cyc_d = 1'b0;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          s_cyc_d   = 1'b0;
          last_d    = owner_q;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_cyc_d = 1'b0;
      end
    endcase
  end

  // Captured request, held unchanged on the slave port for the whole BUSY phase.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      req_q <= '0;
    end else if (load_req) begin
      req_q <= in_req;
    end
  end

  assign s.cyc    = s_cyc_q;
  assign s.stb    = s_cyc_q;
  assign s.we     = req_q.we;
  assign s.sel    = SEL_WIDTH'(req_q.sel);
  assign s.addr   = ADDR_WIDTH'(req_q.addr);
  assign s.data_w = DATA_WIDTH'(req_q.data);

  assign grant_o   = busy ? owner_onehot(owner_q) : 2'b00;
  assign timeout_o = timeout_q;

  // Response path: only the owner sees ack/data, and only in its completion cycle.
  always_comb begin
    m0.ack    = 1'b0;
    m0.data_r = '0;
    m1.ack    = 1'b0;
    m1.data_r = '0;
    resp_data = ack_hit ? s.data_r : ERR_DATA;
    if (!rst_core && (ack_hit || tmo_hit)) begin
      if (owner_q == M1) begin
        m1.ack    = 1'b1;
        m1.data_r = resp_data;
      end else begin
        m0.ack    = 1'b1;
        m0.data_r = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - scoreboard bench for the Wishbone memory arbiter
module tb_wb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  wb_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  wb_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  wb_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

  wb_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_core  (clk),
    .rst_core  (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_req_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } exp_ack_t;

  exp_req_t req_sb[$];
  exp_ack_t ack_sb[$];
  int       total = 0;
  int       bad   = 0;
  logic     prev_cyc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic on, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] data);
    if (k == 0) begin
      m0_bus.cyc = on; m0_bus.stb = on; m0_bus.we = we;
      m0_bus.sel = sel; m0_bus.addr = addr; m0_bus.data_w = data;
    end else begin
      m1_bus.cyc = on; m1_bus.stb = on; m1_bus.we = we;
      m1_bus.sel = sel; m1_bus.addr = addr; m1_bus.data_w = data;
    end
  endtask

  task automatic drop(input int k);
    set_req(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic push_req(input logic owner, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] data);
    exp_req_t e;
    e.owner = owner; e.we = we; e.sel = sel; e.addr = addr; e.data = data;
    req_sb.push_back(e);
  endtask

  task automatic push_ack(input logic owner, input logic [31:0] data);
    exp_ack_t e;
    e.owner = owner; e.data = data;
    ack_sb.push_back(e);
  endtask

  task automatic pop_ack(input logic owner, input logic [31:0] data);
    exp_ack_t e;
    if (ack_sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL ack_unexpected: master %0d acked with %h, expected no ack", owner, data);
    end else begin
      e = ack_sb.pop_front();
      chk("ack_owner", 32'(owner), 32'(e.owner));
      chk("ack_data", data, e.data);
    end
  endtask

  task automatic pop_req();
    exp_req_t e;
    if (req_sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL slave_unexpected: slave cycle to %h, expected none", s_bus.addr);
    end else begin
      e = req_sb.pop_front();
      chk("req_grant", 32'(grant), e.owner ? 32'd2 : 32'd1);
      chk("req_we", 32'(s_bus.we), 32'(e.we));
      chk("req_sel", 32'(s_bus.sel), 32'(e.sel));
      chk("req_addr", s_bus.addr, e.addr);
      chk("req_data", s_bus.data_w, e.data);
    end
  endtask

  task automatic quick_txn(input int k, input logic [31:0] addr, input logic [31:0] rdata);
    set_req(k, 1'b1, 1'b0, 4'hF, addr, 32'h0);
    push_req(k[0], 1'b0, 4'hF, addr, 32'h0);
    tick();
    s_bus.ack = 1'b1; s_bus.data_r = rdata;
    push_ack(k[0], rdata);
    tick();
    s_bus.ack = 1'b0; s_bus.data_r = 32'h0;
    drop(k);
    tick();
  endtask

  // Monitor: pops the scoreboards whenever the DUT acks a master or opens a slave cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_bus.ack) pop_ack(1'b0, m0_bus.data_r);
      else chk("m0_data_quiet", m0_bus.data_r, 32'h0);
      if (m1_bus.ack) pop_ack(1'b1, m1_bus.data_r);
      else chk("m1_data_quiet", m1_bus.data_r, 32'h0);
      if (s_bus.cyc && !prev_cyc) pop_req();
    end
    prev_cyc = s_bus.cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic k;
    drop(0);
    drop(1);
    s_bus.ack = 1'b0;
    s_bus.data_r = 32'h0;
    repeat (3) tick();

    // reset values
    chk("rst_s_cyc", 32'(s_bus.cyc), 32'd0);
    chk("rst_s_stb", 32'(s_bus.stb), 32'd0);
    chk("rst_s_we", 32'(s_bus.we), 32'd0);
    chk("rst_s_sel", 32'(s_bus.sel), 32'd0);
    chk("rst_s_addr", s_bus.addr, 32'd0);
    chk("rst_s_data", s_bus.data_w, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_m0_ack", 32'(m0_bus.ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_bus.ack), 32'd0);
    rst = 1'b0;

    // tie right after reset goes to M0, then grants alternate while both hold
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      k = i[0];
      chk("tie_idle_grant", 32'(grant), 32'd0);
      push_req(k, 1'b0, 4'hF, k ? 32'h20 : 32'h10, 32'h0);
      tick();
      chk("tie_grant", 32'(grant), k ? 32'd2 : 32'd1);
      s_bus.ack = 1'b1;
      s_bus.data_r = 32'hA000_0000 + 32'(i);
      push_ack(k, 32'hA000_0000 + 32'(i));
      tick();
      s_bus.ack = 1'b0;
      s_bus.data_r = 32'h0;
    end
    drop(0);
    drop(1);
    tick();

    // stray slave ack while idle is ignored
    s_bus.ack = 1'b1;
    s_bus.data_r = 32'h0BAD_0BAD;
    tick();
    s_bus.ack = 1'b0;
    s_bus.data_r = 32'h0;
    chk("idle_ack_grant", 32'(grant), 32'd0);
    tick();

    // M0 read with the slave answering in the third busy cycle
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    push_req(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    chk("t1_stb_before", 32'(s_bus.stb), 32'd0);
    tick();
    chk("t1_stb_after", 32'(s_bus.stb), 32'd1);
    tick();
    tick();
    s_bus.ack = 1'b1;
    s_bus.data_r = 32'h1234_5678;
    push_ack(1'b0, 32'h1234_5678);
    chk("t1_m1_ack", 32'(m1_bus.ack), 32'd0);
    tick();
    s_bus.ack = 1'b0;
    s_bus.data_r = 32'h0;
    drop(0);
    chk("t1_stb_drop", 32'(s_bus.stb), 32'd0);
    tick();

    // M1 partial write held stable until the ack
    set_req(1, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hCAFE_F00D);
    push_req(1'b1, 1'b1, 4'b0011, 32'h200, 32'hCAFE_F00D);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_we", 32'(s_bus.we), 32'd1);
      chk("t3_sel", 32'(s_bus.sel), 32'h3);
      chk("t3_data", s_bus.data_w, 32'hCAFE_F00D);
      if (i < 2) tick();
    end
    s_bus.ack = 1'b1;
    s_bus.data_r = 32'h0;
    push_ack(1'b1, 32'h0);
    tick();
    s_bus.ack = 1'b0;
    drop(1);
    tick();

    // M1 abandons its cycle; the slave's late ack must not reach it
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    push_req(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    tick();
    tick();
    drop(1);
    tick();
    chk("t4_idle_cyc", 32'(s_bus.cyc), 32'd0);
    chk("t4_idle_grant", 32'(grant), 32'd0);
    tick();
    s_bus.ack = 1'b1;
    s_bus.data_r = 32'h5555_5555;
    tick();
    s_bus.ack = 1'b0;
    s_bus.data_r = 32'h0;
    tick();

    // slave never answers: forced error ack in the eighth busy cycle
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
    push_req(1'b0, 1'b0, 4'hF, 32'h400, 32'h0);
    tick();
    for (int i = 1; i < 8; i++) begin
      chk("t5_no_timeout_yet", 32'(timeout), 32'd0);
      chk("t5_no_ack_yet", 32'(m0_bus.ack), 32'd0);
      tick();
    end
    push_ack(1'b0, 32'hDEAD_BEEF);
    chk("t5_ack_at_8", 32'(m0_bus.ack), 32'd1);
    tick();
    drop(0);
    chk("t5_timeout_set", 32'(timeout), 32'd1);
    chk("t5_cyc_dropped", 32'(s_bus.cyc), 32'd0);
    tick();
    quick_txn(1, 32'h480, 32'h7777_0001);
    chk("t5_timeout_sticky", 32'(timeout), 32'd1);

    // reset in the middle of a transaction
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    push_req(1'b0, 1'b0, 4'hF, 32'h500, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_cyc", 32'(s_bus.cyc), 32'd0);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    chk("t6_addr", s_bus.addr, 32'd0);
    chk("t6_m0_ack", 32'(m0_bus.ack), 32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
    push_req(1'b0, 1'b0, 4'hF, 32'h600, 32'h0);
    tick();
    chk("t6_tie_m0", 32'(grant), 32'd1);
    s_bus.ack = 1'b1;
    s_bus.data_r = 32'h6666_0000;
    push_ack(1'b0, 32'h6666_0000);
    tick();
    s_bus.ack = 1'b0;
    s_bus.data_r = 32'h0;
    drop(0);
    push_req(1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
    tick();
    chk("t6_pending_m1", 32'(grant), 32'd2);
    s_bus.ack = 1'b1;
    s_bus.data_r = 32'h7000_0007;
    push_ack(1'b1, 32'h7000_0007);
    tick();
    s_bus.ack = 1'b0;
    s_bus.data_r = 32'h0;
    drop(1);
    tick();
    tick();

    chk("req_sb_empty", 32'(req_sb.size()), 32'd0);
    chk("ack_sb_empty", 32'(ack_sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
